// File: rtl/counter_irq_handler_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_irq_handler_if
//  Brief    : Simple register port between the AXI-lite register slave
//             (master side) and counter_irq_handler (slave side).
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_irq_handler_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/counter_irq_handler.sv
`default_nettype none
// ============================================================================
//  Module   : counter_irq_handler
//  Brief    : Sticky/maskable capture of counter-core start/done interrupts,
//             saturating done counter, processor IRQ and core ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_irq_handler #(
    parameter int CNT_W   = 16,
    parameter int ACK_MAX = 255
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            irq_start_in,
    input  wire logic            irq_done_in,
    output logic                 ack_out,
    output logic                 irq_out,
    counter_irq_handler_if.slave bus
);

    localparam int               TMR_W    = (ACK_MAX > 1) ? $clog2(ACK_MAX) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_COUNT   = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             prev_start_q;
    logic             prev_done_q;
    logic             start_seen_q, start_seen_d;
    logic             done_seen_q,  done_seen_d;
    logic             timeout_q,    timeout_d;
    logic             start_ie_q,   start_ie_d;
    logic             done_ie_q,    done_ie_d;
    logic             auto_ack_q,   auto_ack_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             irq_q,        irq_d;
    logic [31:0]      rd_data_q,    rd_data_d;
    ack_state_e       state_q,      state_d;
    logic [TMR_W-1:0] timer_q,      timer_d;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic w_start_rise;
    logic w_done_rise;
    logic w_wr_status;
    logic w_wr_enable;
    logic w_wr_count;
    logic w_wr_control;
    logic w_ack_now;
    logic w_ack_trigger;
    logic w_ack_busy;
    logic w_timeout_evt;
    logic w_unused_wdata;

    assign w_start_rise = irq_start_in & ~prev_start_q;
    assign w_done_rise  = irq_done_in  & ~prev_done_q;

    assign w_wr_status  = bus.wr_en && (bus.wr_addr == ADDR_STATUS);
    assign w_wr_enable  = bus.wr_en && (bus.wr_addr == ADDR_ENABLE);
    assign w_wr_count   = bus.wr_en && (bus.wr_addr == ADDR_COUNT);
    assign w_wr_control = bus.wr_en && (bus.wr_addr == ADDR_CONTROL);
    assign w_ack_now    = w_wr_control & bus.wr_data[1];

    // Clearing done_seen by hand acks the core only when auto-ack is off.
    assign w_ack_trigger = (w_done_rise & auto_ack_q)
                         | (w_wr_status & bus.wr_data[1] & ~auto_ack_q)
                         | w_ack_now;

    assign w_ack_busy     = (state_q == ST_ACK);
    assign w_unused_wdata = ^{bus.wr_data[31:4], bus.wr_data[2]};

    // ------------------------------------------------------------------------
    // Ack handshake FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        w_timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_ack_trigger) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Core release wins over an expiring timer in the same cycle.
                if (!irq_done_in) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    state_d       = ST_IDLE;
                    w_timeout_evt = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register file next state
    // ------------------------------------------------------------------------
    always_comb begin
        start_seen_d = start_seen_q;
        done_seen_d  = done_seen_q;
        timeout_d    = timeout_q;
        start_ie_d   = start_ie_q;
        done_ie_d    = done_ie_q;
        auto_ack_d   = auto_ack_q;
        count_d      = count_q;

        if (w_wr_status) begin
            if (bus.wr_data[0]) start_seen_d = 1'b0;
            if (bus.wr_data[1]) done_seen_d  = 1'b0;
            if (bus.wr_data[3]) timeout_d    = 1'b0;
        end
        if (w_start_rise)  start_seen_d = 1'b1;
        if (w_done_rise)   done_seen_d  = 1'b1;
        if (w_timeout_evt) timeout_d    = 1'b1;

        if (w_wr_enable) begin
            start_ie_d = bus.wr_data[0];
            done_ie_d  = bus.wr_data[1];
        end
        if (w_wr_control) begin
            auto_ack_d = bus.wr_data[0];
        end

        if (w_wr_count) begin
            count_d = w_done_rise ? CNT_W'(1) : '0;
        end else if (w_done_rise && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end

        irq_d = (start_seen_q & start_ie_q) | (done_seen_q & done_ie_q);
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        case (bus.rd_addr)
            ADDR_STATUS:  rd_data_d[3:0]       = {timeout_q, w_ack_busy, done_seen_q, start_seen_q};
            ADDR_ENABLE:  rd_data_d[1:0]       = {done_ie_q, start_ie_q};
            ADDR_COUNT:   rd_data_d[CNT_W-1:0] = count_q;
            ADDR_CONTROL: rd_data_d[0]         = auto_ack_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_start_q <= 1'b0;
            prev_done_q  <= 1'b0;
            start_seen_q <= 1'b0;
            done_seen_q  <= 1'b0;
            timeout_q    <= 1'b0;
            start_ie_q   <= 1'b0;
            done_ie_q    <= 1'b0;
            auto_ack_q   <= 1'b0;
            count_q      <= '0;
            irq_q        <= 1'b0;
            rd_data_q    <= '0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
        end else begin
            prev_start_q <= irq_start_in;
            prev_done_q  <= irq_done_in;
            start_seen_q <= start_seen_d;
            done_seen_q  <= done_seen_d;
            timeout_q    <= timeout_d;
            start_ie_q   <= start_ie_d;
            done_ie_q    <= done_ie_d;
            auto_ack_q   <= auto_ack_d;
            count_q      <= count_d;
            irq_q        <= irq_d;
            rd_data_q    <= rd_data_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
        end
    end

    assign ack_out     = w_ack_busy;
    assign irq_out     = irq_q;
    assign bus.rd_data = rd_data_q;

endmodule
`default_nettype wire
